// File: rtl/router_reg_if.sv
// Byte-stream and FSM-state bundle between the router FSM/bench and router_reg.
interface router_reg_if;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic [7:0] dout;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;

    modport master (
        output pkt_valid, data_in, fifo_full,
        output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        input  dout, parity_done, low_pkt_valid, err
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        output dout, parity_done, low_pkt_valid, err
    );
endinterface

// File: rtl/router_reg.sv
// Router datapath register: header latch, full-stall byte buffer, running parity and parity error flag.
module router_reg (
    input logic          clk,
    input logic          rst,
    router_reg_if.slave  bus
);
    logic [7:0] dout;
    logic [7:0] hdr;
    logic [7:0] ffs_byte;
    logic [7:0] int_parity;
    logic [7:0] pkt_parity;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;
    logic       pd_d;

    logic hdr_load;
    logic pd_set;

    always_comb begin
        hdr_load = bus.detect_add && bus.pkt_valid && (bus.data_in[1:0] != 2'b11);
        pd_set   = (bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
                   (bus.laf_state && low_pkt_valid && !parity_done);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr <= '0;
        end else if (hdr_load) begin
            hdr <= bus.data_in;
        end
    end

    // A byte refused by a full FIFO is parked in ffs_byte and replayed in laf_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout     <= '0;
            ffs_byte <= '0;
        end else begin
            if (bus.lfd_state) begin
                dout <= hdr;
            end else if (bus.ld_state && !bus.fifo_full) begin
                dout <= bus.data_in;
            end else if (bus.laf_state) begin
                dout <= ffs_byte;
            end
            if (bus.ld_state && bus.fifo_full) begin
                ffs_byte <= bus.data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            int_parity <= '0;
            pkt_parity <= '0;
        end else if (bus.detect_add) begin
            int_parity <= '0;
            pkt_parity <= '0;
        end else begin
            if (bus.lfd_state) begin
                int_parity <= int_parity ^ hdr;
            end else if (bus.ld_state && bus.pkt_valid && !bus.full_state) begin
                int_parity <= int_parity ^ bus.data_in;
            end
            if (bus.ld_state && !bus.pkt_valid) begin
                pkt_parity <= bus.data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_done   <= 1'b0;
            low_pkt_valid <= 1'b0;
            pd_d          <= 1'b0;
            err           <= 1'b0;
        end else begin
            pd_d <= parity_done;
            if (bus.detect_add) begin
                parity_done <= 1'b0;
            end else if (pd_set) begin
                parity_done <= 1'b1;
            end
            if (bus.rst_int_reg) begin
                low_pkt_valid <= 1'b0;
            end else if (bus.ld_state && !bus.pkt_valid) begin
                low_pkt_valid <= 1'b1;
            end
            // Compare once, the cycle after parity_done rises, so pkt_parity is settled.
            if (bus.detect_add) begin
                err <= 1'b0;
            end else if (parity_done && !pd_d) begin
                err <= (int_parity != pkt_parity);
            end
        end
    end

    assign bus.dout          = dout;
    assign bus.parity_done   = parity_done;
    assign bus.low_pkt_valid = low_pkt_valid;
    assign bus.err           = err;
endmodule
